ambm_seq: RTL and testbench
===========================

Name: ambm_seq

Overview:
- Sequential, parametrised successor of the combinational 16x16 approximate radix-4 Booth multiplier (PPG-2S partial-product generator).
- Multiplies two signed WIDTH-bit operands by generating PP_PER_CYCLE approximate Booth rows per clock into an accumulator.
- Sits in the datapath behind a valid/ready source and drives a valid/ready sink, trading latency for area.

Parameters:
- WIDTH, 16, operand width; even, >=4.
- PP_PER_CYCLE, 2, Booth rows summed per cycle; must divide WIDTH/2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  signed multiplicand.
- in_b  in  WIDTH  signed multiplier.
- in_exact  in  1  per-transaction exact-mode request (see Optional Feature).
- out_valid  out  1  product valid.
- out_ready  in  1  sink accepts product.
- out_p  out  2*WIDTH  signed product.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, out_p=0, accumulator/counters 0.
- Digit i (0..WIDTH/2-1) = {b[2i+1], b[2i], b[2i-1]}, b[-1]=0.
- Encoding {neg,zero}: 000->01, 001/010/011->00, 100/101/110->10, 111->01.
- Row: or = neg ? ~A : (zero ? 0 : A); row_i = {or[W-1:1], or[0] | b[2i+1]}; sign-extend to 2*WIDTH and shift left by 2i.
- The two flag is deliberately ignored: +-2A is approximated as +-A.
- out_p = sum of all rows, mod 2^(2*WIDTH). This is the bit-exact golden model.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B and mode, clear accumulator, clear digit counter, go to RUN.
  - RUN: in_ready=0. Each cycle add PP_PER_CYCLE rows (digits cnt..cnt+PP_PER_CYCLE-1) and advance cnt by PP_PER_CYCLE. After D=WIDTH/(2*PP_PER_CYCLE) cycles, register out_p, set out_valid=1, go to DONE.
  - DONE: out_valid=1 and out_p stable until out_valid&&out_ready. On that cycle go to IDLE with out_valid=0.
- Latency: out_valid rises D clock edges after the accept edge. With defaults, D=4.
- Throughput: one product per D+2 cycles when out_ready is held high. There is no accept in DONE, so no overlap.
- in_valid is ignored outside IDLE, and operand changes in RUN/DONE have no effect.
- out_ready low in DONE stalls indefinitely without data loss.
- Reset mid-RUN or mid-DONE aborts the operation; no output is produced.
- Most-negative operands are legal and follow the golden model, with no saturation.

Optional Feature:
- Macro AMBM_EXACT_EN.
- Defined: when the latched in_exact=1, rows use exact radix-4 Booth: +-A or +-2A, zero, negation by ~ plus a +1 correction bit at position 2i. out_p then equals the true signed product A*B. When in_exact=0, behaviour is approximate as above.
- Undefined: in_exact is ignored and every transaction is approximate. Latency is identical in both builds.

Decomposition:
- Package ambm_pkg holds:
  - FSM state typedef (IDLE, RUN, DONE);
  - Booth digit encoding constants;
  - the function computing {neg, two, zero} from a 3-bit digit.
- Sub-module ambm_ppg: one combinational row generator with inputs A, digit, the b[2i+1] bit and exact flag, and output a 2*WIDTH-bit shifted, sign-extended row. It is instantiated PP_PER_CYCLE times.

Test Plan:
- WIDTH=16, A=3, B=2, approximate -> out_p=32'h00000009 (exact would be 6). out_valid rises 4 edges after accept.
- A=5, B=-1 (16'hFFFF), approximate -> out_p=32'h0000554F (21839). With AMBM_EXACT_EN and in_exact=1 -> 32'hFFFFFFFB.
- A=5, B=1 -> out_p=5. A=0, B=0 -> out_p=0. Then run random A/B against the golden model, including 16'h8000 operands.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_p stable, in_ready=0, and a new in_valid is ignored. Release -> handshake completes and in_ready=1 next cycle.
- Assert rst_n=0 in the 2nd RUN cycle -> outputs return to reset values immediately, and no spurious out_valid appears after release.
- Sweep PP_PER_CYCLE in {1, 2, 4, 8} for WIDTH=16, plus WIDTH=8 -> products match the golden model and latency equals WIDTH/(2*PP_PER_CYCLE).

Source files
------------

// File: rtl/ambm_pkg.sv
// rtl/ambm_pkg.sv - shared FSM state codes and radix-4 Booth digit encoding for ambm_seq
package ambm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Encoded as {neg, two, zero}
  localparam logic [2:0] ENC_POS1 = 3'b000;
  localparam logic [2:0] ENC_ZERO = 3'b001;
  localparam logic [2:0] ENC_POS2 = 3'b010;
  localparam logic [2:0] ENC_NEG1 = 3'b100;
  localparam logic [2:0] ENC_NEG2 = 3'b110;

  function automatic logic [2:0] booth_enc(input logic [2:0] digit);
    case (digit)
      3'b000, 3'b111: booth_enc = ENC_ZERO;
      3'b001, 3'b010: booth_enc = ENC_POS1;
      3'b011:         booth_enc = ENC_POS2;
      3'b100:         booth_enc = ENC_NEG2;
      default:        booth_enc = ENC_NEG1;
    endcase
  endfunction

endpackage

// File: rtl/ambm_ppg.sv
// rtl/ambm_ppg.sv - one radix-4 Booth row: approximate PPG-2S (two ignored) or exact Booth
module ambm_ppg
  import ambm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PW    = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [2:0]         digit,
  input  logic               b_hi,
  input  logic               exact,
  input  logic [PW-1:0]      pos,
  output logic [2*WIDTH-1:0] row
);

  logic                 neg;
  logic                 two;
  logic                 zero;
  logic [WIDTH-1:0]     or_v;
  logic [WIDTH-1:0]     apx;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   mag;
  logic [2*WIDTH-1:0]   exr;
  logic [2*WIDTH-1:0]   base;

  always_comb begin
    {neg, two, zero} = booth_enc(digit);

    // Approximate row: the missing +1 of the negation is replaced by OR-ing b[2i+1] into bit 0
    or_v = neg ? ~a : (zero ? '0 : a);
    apx  = {or_v[WIDTH-1:1], or_v[0] | b_hi};

    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    mag   = zero ? '0 : (two ? (a_ext << 1) : a_ext);
    exr   = (neg ? ~mag : mag) + {{(2*WIDTH-1){1'b0}}, neg};

    base = exact ? exr : {{WIDTH{apx[WIDTH-1]}}, apx};
    row  = base << {pos, 1'b0};
  end

endmodule

// File: rtl/ambm_seq.sv
// rtl/ambm_seq.sv - sequential approximate Booth multiplier, PP_PER_CYCLE rows per clock
// Optional AMBM_EXACT_EN: per-transaction exact radix-4 Booth rows selected by in_exact.
module ambm_seq
  import ambm_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int PP_PER_CYCLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_exact,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = $clog2(NDIG) + 1;
  localparam logic [CW-1:0] STEP     = CW'(PP_PER_CYCLE);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - PP_PER_CYCLE);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               exact_q;
  logic               exact_in;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] rows [PP_PER_CYCLE];
  logic [WIDTH:0]     b_ext;

`ifdef AMBM_EXACT_EN
  assign exact_in = in_exact;
`else
  logic unused_exact;
  assign unused_exact = in_exact;
  assign exact_in     = 1'b0;
`endif

  // b[-1] = 0 sits at bit 0 so digit i starts at bit 2i
  assign b_ext = {b_q, 1'b0};

  for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_row
    logic [CW-1:0] idx;
    logic [2:0]    dig;

    assign idx = cnt + CW'(k);
    assign dig = 3'(b_ext >> {idx, 1'b0});

    ambm_ppg #(
      .WIDTH (WIDTH),
      .PW    (CW)
    ) u_ppg (
      .a     (a_q),
      .digit (dig),
      .b_hi  (dig[2]),
      .exact (exact_q),
      .pos   (idx),
      .row   (rows[k])
    );
  end

  always_comb begin
    acc_next = acc;
    for (int k = 0; k < PP_PER_CYCLE; k++) begin
      acc_next = acc_next + rows[k];
    end
  end

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      exact_q   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            exact_q <= exact_in;
            acc     <= '0;
            cnt     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt + STEP;
          if (cnt == LAST_CNT) begin
            out_p     <= acc_next;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ambm_seq.sv
// tb/tb_ambm_seq.sv - directed self-checking bench for ambm_seq, plus PP_PER_CYCLE/WIDTH sweep instances
module tb_ambm_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_exact;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        sw_valid;

  logic        r_pp1, r_pp4, r_pp8, r_w8;
  logic        v_pp1, v_pp4, v_pp8, v_w8;
  logic [31:0] p_pp1, p_pp4, p_pp8;
  logic [15:0] p_w8;

  int compares   = 0;
  int mismatches = 0;

  always #5 clk = ~clk;

  ambm_seq #(.WIDTH(16), .PP_PER_CYCLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  ambm_seq #(.WIDTH(16), .PP_PER_CYCLE(1)) u_pp1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r_pp1),
    .in_a(in_a), .in_b(in_b), .in_exact(1'b0),
    .out_valid(v_pp1), .out_ready(1'b1), .out_p(p_pp1)
  );

  ambm_seq #(.WIDTH(16), .PP_PER_CYCLE(4)) u_pp4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r_pp4),
    .in_a(in_a), .in_b(in_b), .in_exact(1'b0),
    .out_valid(v_pp4), .out_ready(1'b1), .out_p(p_pp4)
  );

  ambm_seq #(.WIDTH(16), .PP_PER_CYCLE(8)) u_pp8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r_pp8),
    .in_a(in_a), .in_b(in_b), .in_exact(1'b0),
    .out_valid(v_pp8), .out_ready(1'b1), .out_p(p_pp8)
  );

  ambm_seq #(.WIDTH(8), .PP_PER_CYCLE(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r_w8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_exact(1'b0),
    .out_valid(v_w8), .out_ready(1'b1), .out_p(p_w8)
  );

  // Bit-level golden model for a w-bit approximate multiply (w <= 16), result masked to 2w bits
  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b, input int w);
    logic [31:0] acc;
    logic [31:0] row;
    logic [16:0] bx;
    logic [2:0]  d;
    logic [15:0] orv;
    logic [15:0] rv;
    logic        neg;
    logic        zero;
    acc = '0;
    bx  = {b, 1'b0};
    for (int i = 0; i < w / 2; i++) begin
      d    = bx[2*i +: 3];
      neg  = d[2] & ~(d[1] & d[0]);
      zero = (d == 3'b000) || (d == 3'b111);
      orv  = neg ? ~a : (zero ? 16'h0 : a);
      rv   = {orv[15:1], orv[0] | d[2]};
      row  = '0;
      for (int j = 0; j < 2 * w; j++) begin
        row[j] = (j < w) ? rv[j] : rv[w-1];
      end
      acc = acc + (row << (2 * i));
    end
    if (w < 16) acc = acc & ((32'h1 << (2 * w)) - 32'h1);
    return acc;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compares++;
    assert (observed === expected)
    else begin
      mismatches++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Entered #1 after a posedge with the DUT idle; leaves it idle again
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic ex,
                        input logic [31:0] exp_p, input string tag);
    int lat;
    lat      = 0;
    in_a     = a;
    in_b     = b;
    in_exact = ex;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) lat = k;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_p"}, 64'(out_p), 64'(exp_p));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ack"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  task automatic do_sweep(input logic [15:0] a, input logic [15:0] b, input string tag);
    int          lat [4];
    logic [31:0] cap [4];
    for (int j = 0; j < 4; j++) begin
      lat[j] = 0;
      cap[j] = '0;
    end
    in_a     = a;
    in_b     = b;
    sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (v_pp1 && lat[0] == 0) begin lat[0] = k; cap[0] = p_pp1; end
      if (v_pp4 && lat[1] == 0) begin lat[1] = k; cap[1] = p_pp4; end
      if (v_pp8 && lat[2] == 0) begin lat[2] = k; cap[2] = p_pp8; end
      if (v_w8  && lat[3] == 0) begin lat[3] = k; cap[3] = {16'h0, p_w8}; end
    end
    check({tag, "_pp1_lat"}, 64'(lat[0]), 64'd8);
    check({tag, "_pp1_p"},   64'(cap[0]), 64'(golden(a, b, 16)));
    check({tag, "_pp4_lat"}, 64'(lat[1]), 64'd2);
    check({tag, "_pp4_p"},   64'(cap[1]), 64'(golden(a, b, 16)));
    check({tag, "_pp8_lat"}, 64'(lat[2]), 64'd1);
    check({tag, "_pp8_p"},   64'(cap[2]), 64'(golden(a, b, 16)));
    check({tag, "_w8_lat"},  64'(lat[3]), 64'd2);
    check({tag, "_w8_p"},    64'(cap[3]), 64'(golden({8'h0, a[7:0]}, {8'h0, b[7:0]}, 8)));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] held;
    logic        stall_ok;
    logic        seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sw_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_exact  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_p",     64'(out_p),     64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(16'd3, 16'd2,    1'b0, 32'h00000009, "a3b2");
    do_txn(16'd5, 16'hFFFF, 1'b0, 32'h0000554F, "a5bm1");
`ifdef AMBM_EXACT_EN
    do_txn(16'd5, 16'hFFFF, 1'b1, 32'hFFFFFFFB, "a5bm1_exact");
`else
    do_txn(16'd5, 16'hFFFF, 1'b1, 32'h0000554F, "a5bm1_exact_ignored");
`endif
    do_txn(16'd5, 16'd1, 1'b0, 32'h00000005, "a5b1");
    do_txn(16'd0, 16'd0, 1'b0, 32'h00000000, "a0b0");
    do_txn(16'h8000, 16'h8000, 1'b0, golden(16'h8000, 16'h8000, 16), "min_min");
    do_txn(16'h8000, 16'hFFFF, 1'b0, golden(16'h8000, 16'hFFFF, 16), "min_m1");
    do_txn(16'h7FFF, 16'h8000, 1'b0, golden(16'h7FFF, 16'h8000, 16), "max_min");
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_txn(ra, rb, 1'b0, golden(ra, rb, 16), "rand");
    end

    // Stall in DONE with a competing in_valid that must be ignored
    in_a     = 16'd7;
    in_b     = 16'd9;
    in_exact = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen     = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    check("stall_reach_done", 64'(seen), 64'd1);
    held     = out_p;
    check("stall_p", 64'(held), 64'(golden(16'd7, 16'd9, 16)));
    in_a     = 16'h1234;
    in_b     = 16'h4321;
    in_valid = 1'b1;
    stall_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!out_valid || out_p !== held || in_ready) stall_ok = 1'b0;
    end
    check("stall_hold", 64'(stall_ok), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release", 64'({in_ready, out_valid}), 64'(2'b10));

    // Reset during the second RUN cycle
    in_a     = 16'd11;
    in_b     = 16'd13;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_p",     64'(out_p),     64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_spurious", 64'(seen), 64'd0);

    do_sweep(16'd3, 16'd2, "sw_a3b2");
    do_sweep(16'h8000, 16'h8000, "sw_min");
    do_sweep(16'hB5C3, 16'h6A97, "sw_mix");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
